// File: rtl/aludec_pkg.sv
// Shared constants and state type for the ALU decoder / vector beat sequencer.
package aludec_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b000;
    localparam logic [2:0] ALU_VSUM = 3'b011;
    localparam logic [2:0] ALU_VSET = 3'b111;
    localparam logic [2:0] ALU_SKIP = 3'b100;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ARITH_A = 6'b010000;
    localparam logic [5:0] OP_ARITH_B = 6'b000100;
    localparam logic [5:0] OP_ARITH_C = 6'b001100;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_SUB  = 6'b000001;
    localparam logic [5:0] F_ADDU = 6'b000100;
    localparam logic [5:0] F_MUL  = 6'b000110;
    localparam logic [5:0] F_VADD = 6'b100100;
    localparam logic [5:0] F_VMUL = 6'b100110;
    localparam logic [5:0] F_VSUM = 6'b110000;

    typedef enum logic [1:0] {IDLE, ISSUE, REDUCE} aludec_state_t;

    function automatic logic is_arith(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ARITH_A) || (op == OP_ARITH_B) || (op == OP_ARITH_C);
    endfunction

endpackage

// File: rtl/aludec_table.sv
// Combinational decode of (opcode, funct, aluop) into ALU control plus vector/vsum flags.
module aludec_table
    import aludec_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol,
    output logic       is_vec,
    output logic       is_vsum
);

    logic arith;

    always_comb begin
        arith      = is_arith(opcode);
        alucontrol = ALU_SKIP;
        if (arith) begin
            if (aluop == 2'b00) begin
                alucontrol = ALU_ADD;
            end else if (aluop == 2'b01) begin
                alucontrol = ALU_VSET;
            end else begin
                unique case (funct)
                    F_ADD, F_ADDU, F_VADD: alucontrol = ALU_ADD;
                    F_SUB:                 alucontrol = ALU_SUB;
                    F_MUL, F_VMUL:         alucontrol = ALU_MUL;
                    F_VSUM:                alucontrol = ALU_VSUM;
                    default:               alucontrol = ALU_SKIP;
                endcase
            end
        end
        is_vec  = aluop[1] && arith && funct[5] && (alucontrol != ALU_SKIP);
        is_vsum = is_vec && (funct == F_VSUM);
    end

endmodule

// File: rtl/aludec_vseq.sv
// ALU decoder with vector beat sequencer (IDLE/ISSUE/REDUCE) and registered beat outputs.
// Optional perf counters enabled by defining ALUDEC_PERF_EN.
module aludec_vseq
    import aludec_pkg::*;
#(
    parameter int VLEN  = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 32,
    localparam int BEATS = VLEN / LANES,
    localparam int LW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [1:0]    aluop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    alucontrol,
    output logic [LW-1:0] lane_idx,
    output logic          out_first,
    output logic          out_last,
    output logic          out_reduce,
    output logic          busy
`ifdef ALUDEC_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_instr,
    output logic [CNT_W-1:0] perf_beats,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    if ((VLEN % LANES) != 0 || VLEN < LANES || CNT_W < 1) begin : g_cfg_check
        $error("aludec_vseq: illegal VLEN/LANES/CNT_W");
    end

    aludec_state_t state_q, state_d;
    logic          valid_q, valid_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          reduce_q, reduce_d;
    logic          vsum_q, vsum_d;

    logic [2:0] dec_ctrl;
    logic       dec_vec;
    logic       dec_vsum;
    logic       hs;
    logic       accept;

    aludec_table u_table (
        .opcode     (opcode),
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (dec_ctrl),
        .is_vec     (dec_vec),
        .is_vsum    (dec_vsum)
    );

    assign hs       = valid_q && out_ready;
    assign in_ready = !rst && ((state_q == IDLE) || (hs && last_q));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        lane_d   = lane_q;
        first_d  = first_q;
        last_d   = last_q;
        reduce_d = reduce_q;
        vsum_d   = vsum_q;

        if (hs) begin
            if (last_q) begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                lane_d   = '0;
                first_d  = 1'b0;
                last_d   = 1'b0;
                reduce_d = 1'b0;
                vsum_d   = 1'b0;
            end else if (lane_q == LW'(BEATS - 1)) begin
                // Only a vsum sequence reaches its final lane group without last set.
                state_d  = REDUCE;
                ctrl_d   = ALU_VSUM;
                lane_d   = '0;
                first_d  = 1'b0;
                last_d   = 1'b1;
                reduce_d = 1'b1;
            end else begin
                lane_d  = lane_q + LW'(1);
                first_d = 1'b0;
                last_d  = (lane_q + LW'(1) == LW'(BEATS - 1)) && !vsum_q;
            end
        end

        // An accept can only coincide with the last-beat handshake, so it overrides it.
        if (accept) begin
            if (dec_ctrl == ALU_SKIP) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                state_d  = ISSUE;
                valid_d  = 1'b1;
                ctrl_d   = dec_ctrl;
                lane_d   = '0;
                first_d  = 1'b1;
                last_d   = !dec_vec || ((BEATS == 1) && !dec_vsum);
                reduce_d = 1'b0;
                vsum_d   = dec_vsum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            ctrl_q   <= ALU_SKIP;
            lane_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            reduce_q <= 1'b0;
            vsum_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            lane_q   <= lane_d;
            first_q  <= first_d;
            last_q   <= last_d;
            reduce_q <= reduce_d;
            vsum_q   <= vsum_d;
        end
    end

    assign out_valid  = valid_q;
    assign alucontrol = ctrl_q;
    assign lane_idx   = lane_q;
    assign out_first  = first_q;
    assign out_last   = last_q;
    assign out_reduce = reduce_q;
    assign busy       = (state_q != IDLE);

`ifdef ALUDEC_PERF_EN
    logic [CNT_W-1:0] instr_q, beats_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            beats_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept && dec_ctrl != ALU_SKIP && instr_q != '1) instr_q <= instr_q + 1'b1;
            if (hs && beats_q != '1) beats_q <= beats_q + 1'b1;
            if (valid_q && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign perf_instr = instr_q;
    assign perf_beats = beats_q;
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_aludec_vseq.sv
// Scoreboard bench for aludec_vseq: directed scenarios plus randomized instruction stream.
module tb_aludec_vseq;

    typedef struct packed {
        logic [2:0] c;
        logic [1:0] lane;
        logic       first;
        logic       last;
        logic       red;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [1:0] aluop = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] alucontrol;
    logic [1:0] lane_idx;
    logic       out_first, out_last, out_reduce, busy;
`ifdef ALUDEC_PERF_EN
    logic [31:0] perf_instr, perf_beats, perf_stall;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    int    rdy_mode = 2;
    beat_t sb[$];

    aludec_vseq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct      (funct),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alucontrol (alucontrol),
        .lane_idx   (lane_idx),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_reduce (out_reduce),
        .busy       (busy)
`ifdef ALUDEC_PERF_EN
        ,
        .perf_instr (perf_instr),
        .perf_beats (perf_beats),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expand one instruction into its expected beat list.
    function automatic void model_push(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [1:0] ao);
        logic [2:0] c;
        bit arith, vec, vsum;
        int n;
        arith = (op == 6'd0) || (op == 6'b010000) || (op == 6'b000100) || (op == 6'b001100);
        if (!arith)         c = 3'b100;
        else if (ao == 2'd0) c = 3'b010;
        else if (ao == 2'd1) c = 3'b111;
        else begin
            case (fn)
                6'b000000, 6'b000100, 6'b100100: c = 3'b010;
                6'b000001:                       c = 3'b110;
                6'b000110, 6'b100110:            c = 3'b000;
                6'b110000:                       c = 3'b011;
                default:                         c = 3'b100;
            endcase
        end
        if (c == 3'b100) return;
        vec  = ao[1] && fn[5];
        vsum = vec && (fn == 6'b110000);
        n    = vec ? 4 : 1;
        for (int i = 0; i < n; i++)
            sb.push_back('{c, 2'(i), i == 0, (i == n - 1) && !vsum, 1'b0});
        if (vsum) sb.push_back('{3'b011, 2'd0, 1'b0, 1'b1, 1'b1});
    endfunction

    // Monitor: pop expected beat on every handshake; check hold during stalls.
    beat_t prev_b;
    bit    prev_stall = 0;
    initial begin
        forever begin
            beat_t b, e;
            @(negedge clk);
            b = '{alucontrol, lane_idx, out_first, out_last, out_reduce};
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", 32'(out_valid), 32'd1);
                    chk("stall_payload_hold", 32'(b), 32'(prev_b));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 32'(b), 32'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", 32'(b), 32'(e));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_b     = b;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] ao);
        int n = 0;
        bit ok = 0;
        in_valid = 1'b1;
        opcode   = op;
        funct    = fn;
        aluop    = ao;
        while (!ok) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else if (++n > 300) break;
        end
        if (ok) model_push(op, fn, ao);
        else chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 6'($urandom);
        funct    = 6'($urandom);
        aluop    = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 || busy) begin
            @(negedge clk);
            if (++n > 500) begin
                chk("drain_timeout", 32'(sb.size()), 32'd0);
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ctrl"}, 32'(alucontrol), 32'h4);
        chk({tag, "_lane"}, 32'(lane_idx), 32'd0);
        chk({tag, "_flags"}, 32'({out_first, out_last, out_reduce}), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
`ifdef ALUDEC_PERF_EN
        logic [31:0] stall0;
`endif
        logic [5:0] ops[6];
        logic [5:0] fns[8];
        ops = '{6'b000000, 6'b010000, 6'b000100, 6'b001100, 6'b100011, 6'b101011};
        fns = '{6'b000000, 6'b000001, 6'b000100, 6'b000110, 6'b100100, 6'b100110,
                6'b110000, 6'b100001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Scalar SUB: one beat at N+1, in_ready high again.
        issue(6'b000000, 6'b000001, 2'b10);
        @(negedge clk);
        chk("scalar_latency", 32'(out_valid), 32'd1);
        chk("scalar_ctrl", 32'(alucontrol), 32'h6);
        chk("scalar_in_ready", 32'(in_ready), 32'd1);
        drain();

        issue(6'b000100, 6'b100110, 2'b10);  // vmul: 4 beats
        drain();
        issue(6'b000000, 6'b110000, 2'b10);  // vsum: 4 + reduce
        drain();

        // Load opcode: no beat, in_ready stays high.
        issue(6'b100011, 6'b100110, 2'b10);
        @(negedge clk);
        chk("skip_no_valid", 32'(out_valid), 32'd0);
        chk("skip_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back scalars then a vector, no bubbles expected by the scoreboard.
        fork
            begin
                issue(6'b010000, 6'b000000, 2'b00);
                issue(6'b001100, 6'b000000, 2'b01);
                issue(6'b000000, 6'b100100, 2'b11);
            end
        join
        drain();

        // vadd with a 3-cycle stall on beat 2.
`ifdef ALUDEC_PERF_EN
        stall0 = perf_stall;
`endif
        issue(6'b000000, 6'b100100, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_lane", 32'(lane_idx), 32'd2);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
`ifdef ALUDEC_PERF_EN
        chk("perf_stall_delta", perf_stall - stall0, 32'd3);
`endif

        // Reset during beat 1 of vmul.
        issue(6'b000100, 6'b100110, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(6'b000100, 6'b100110, 2'b10);
        drain();

        // Randomized stream with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            issue(op, fn, 2'($urandom));
        end
        drain();
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
